// File: rtl/lna_pkg.sv
// Shared definitions for the LNA/PA transmit-receive sequencer.
// Holds the FSM state encoding, the default bias-settle, dead-time and
// transmit-dwell lengths, the dwell counter width, and small state helpers.
package lna_pkg;

    localparam int unsigned CNT_W         = 11;
    localparam int unsigned SETTLE_CYCLES = 8;
    localparam int unsigned GUARD_CYCLES  = 4;
    localparam int unsigned TX_MAX_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RX_SETTLE = 3'd1,
        ST_RX_ON     = 3'd2,
        ST_GUARD     = 3'd3,
        ST_TX_SETTLE = 3'd4,
        ST_TX_ON     = 3'd5,
        ST_FAULT     = 3'd6
    } lna_state_e;

    // True for the states that drive the receive enable.
    function automatic logic is_rx_state(input lna_state_e st);
        return (st == ST_RX_SETTLE) || (st == ST_RX_ON);
    endfunction

    // True for the states that drive the transmit enable.
    function automatic logic is_tx_state(input lna_state_e st);
        return (st == ST_TX_SETTLE) || (st == ST_TX_ON);
    endfunction

endpackage

// File: rtl/lna_dwell_counter.sv
// Dwell counter shared by the settle, guard and transmit-timeout intervals.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   load   in  restart the count at 0 (asserted on every state entry)
//   en     in  advance the count
//   limit  in  terminal value; the count saturates there and never wraps
//   tc     out count currently equals limit
module lna_dwell_counter
    import lna_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_r;

    // Count register: reload on entry, otherwise climb until the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != limit)) begin
            cnt_r <= cnt_r + WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == limit);

endmodule

// File: rtl/lna_trx_sequencer.sv
// Sequences the front-end LNA/PA path between receive and transmit.
// Arbitrates RX/TX requests, inserts bias-settle and dead-time intervals so
// the two enables are never high together, and forces transmit off on a
// dwell timeout or an over-temperature alarm.
// Ports:
//   Clock          in  system clock, rising edge
//   ResetN         in  asynchronous active-low reset
//   RxReq          in  level request for the receive path
//   TxReq          in  level request for the transmit path (wins over RxReq)
//   TempAlarm      in  junction over-temperature, already synchronised
//   EnableReceive  out LNA receive enable
//   EnableTransmit out PA transmit enable
//   RxReady        out receive path settled
//   TxReady        out transmit path settled
//   TxAbort        out one-cycle pulse when transmit is forced off
//   Busy           out high whenever the sequencer is not idle
module lna_trx_sequencer
    import lna_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = lna_pkg::SETTLE_CYCLES,
    parameter int unsigned GUARD_CYCLES  = lna_pkg::GUARD_CYCLES,
    parameter int unsigned TX_MAX_CYCLES = lna_pkg::TX_MAX_CYCLES,
    parameter int unsigned CNT_W         = lna_pkg::CNT_W
) (
    input  logic Clock,
    input  logic ResetN,
    input  logic RxReq,
    input  logic TxReq,
    input  logic TempAlarm,
    output logic EnableReceive,
    output logic EnableTransmit,
    output logic RxReady,
    output logic TxReady,
    output logic TxAbort,
    output logic Busy
);

    // Terminal counts: an interval of N cycles ends when the count shows N-1.
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LIM  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TX_LIM     = CNT_W'(TX_MAX_CYCLES - 1);

    lna_state_e       state_r;
    lna_state_e       next_state_s;
    logic             abort_s;
    logic             load_s;
    logic             tc_s;
    logic [CNT_W-1:0] limit_s;

    logic en_rx_r;
    logic en_tx_r;
    logic rdy_rx_r;
    logic rdy_tx_r;
    logic abort_r;
    logic busy_r;

    // Select the interval length that applies to the current state.
    always_comb begin
        limit_s = '0;
        case (state_r)
            ST_RX_SETTLE: limit_s = SETTLE_LIM;
            ST_TX_SETTLE: limit_s = SETTLE_LIM;
            ST_GUARD:     limit_s = GUARD_LIM;
            ST_TX_ON:     limit_s = TX_LIM;
            default:      limit_s = '0;
        endcase
    end

    lna_dwell_counter #(
        .WIDTH (CNT_W)
    ) u_dwell (
        .clk   (Clock),
        .rst_n (ResetN),
        .load  (load_s),
        .en    (1'b1),
        .limit (limit_s),
        .tc    (tc_s)
    );

    // Next-state and abort decision; TempAlarm outranks timeout, which
    // outranks TxReq, which outranks RxReq.
    always_comb begin
        next_state_s = state_r;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (TxReq && !TempAlarm) begin
                    next_state_s = ST_TX_SETTLE;
                end else if (RxReq && !TempAlarm) begin
                    next_state_s = ST_RX_SETTLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RX_SETTLE: begin
                if (TempAlarm) begin
                    next_state_s = ST_FAULT;
                end else if (TxReq || !RxReq) begin
                    next_state_s = ST_GUARD;
                end else if (tc_s) begin
                    next_state_s = ST_RX_ON;
                end else begin
                    next_state_s = ST_RX_SETTLE;
                end
            end
            ST_RX_ON: begin
                if (TempAlarm) begin
                    next_state_s = ST_FAULT;
                end else if (TxReq || !RxReq) begin
                    next_state_s = ST_GUARD;
                end else begin
                    next_state_s = ST_RX_ON;
                end
            end
            ST_TX_SETTLE: begin
                if (TempAlarm) begin
                    next_state_s = ST_FAULT;
                    abort_s      = 1'b1;
                end else if (!TxReq) begin
                    next_state_s = ST_GUARD;
                end else if (tc_s) begin
                    next_state_s = ST_TX_ON;
                end else begin
                    next_state_s = ST_TX_SETTLE;
                end
            end
            ST_TX_ON: begin
                if (TempAlarm || tc_s) begin
                    next_state_s = ST_FAULT;
                    abort_s      = 1'b1;
                end else if (!TxReq) begin
                    next_state_s = ST_GUARD;
                end else begin
                    next_state_s = ST_TX_ON;
                end
            end
            ST_GUARD: begin
                if (TempAlarm) begin
                    next_state_s = ST_FAULT;
                end else if (!tc_s) begin
                    next_state_s = ST_GUARD;
                end else if (TxReq) begin
                    next_state_s = ST_TX_SETTLE;
                end else if (RxReq) begin
                    next_state_s = ST_RX_SETTLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FAULT: begin
                // Requesters must let go before the path is re-armed.
                if (!TempAlarm && !TxReq && !RxReq) begin
                    next_state_s = ST_GUARD;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_FAULT;
            end
        endcase
    end

    assign load_s = (next_state_s != state_r);

    // State and output registers; outputs are decoded from the next state
    // so they change on the same edge as the state itself.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r  <= ST_IDLE;
            en_rx_r  <= 1'b0;
            en_tx_r  <= 1'b0;
            rdy_rx_r <= 1'b0;
            rdy_tx_r <= 1'b0;
            abort_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            en_rx_r  <= is_rx_state(next_state_s);
            en_tx_r  <= is_tx_state(next_state_s);
            rdy_rx_r <= (next_state_s == ST_RX_ON);
            rdy_tx_r <= (next_state_s == ST_TX_ON);
            abort_r  <= abort_s;
            busy_r   <= (next_state_s != ST_IDLE);
        end
    end

    assign EnableReceive  = en_rx_r;
    assign EnableTransmit = en_tx_r;
    assign RxReady        = rdy_rx_r;
    assign TxReady        = rdy_tx_r;
    assign TxAbort        = abort_r;
    assign Busy           = busy_r;

endmodule

// File: tb/tb_lna_trx_sequencer.sv
// Self-checking bench for lna_trx_sequencer: directed scenarios with timing
// checks plus a randomized run, all compared against a mode/age model.
module tb_lna_trx_sequencer;

    localparam int SETTLE = 8;
    localparam int GUARD  = 4;
    localparam int TXMAX  = 1024;

    localparam int MD_IDLE  = 0;
    localparam int MD_RX    = 1;
    localparam int MD_TX    = 2;
    localparam int MD_DEAD  = 3;
    localparam int MD_FAULT = 4;

    logic Clock = 1'b0;
    logic ResetN;
    logic RxReq;
    logic TxReq;
    logic TempAlarm;
    logic EnableReceive;
    logic EnableTransmit;
    logic RxReady;
    logic TxReady;
    logic TxAbort;
    logic Busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: which path is up, and how many edges it has been up.
    int m_mode;
    int m_age;
    bit m_abort;

    logic [5:0] dut_vec;
    assign dut_vec = {EnableReceive, EnableTransmit, RxReady, TxReady, TxAbort, Busy};

    lna_trx_sequencer dut (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .RxReq          (RxReq),
        .TxReq          (TxReq),
        .TempAlarm      (TempAlarm),
        .EnableReceive  (EnableReceive),
        .EnableTransmit (EnableTransmit),
        .RxReady        (RxReady),
        .TxReady        (TxReady),
        .TxAbort        (TxAbort),
        .Busy           (Busy)
    );

    always #5 Clock = ~Clock;

    // Both enables high together is never acceptable.
    assert property (@(posedge Clock) disable iff (!ResetN) !(EnableReceive && EnableTransmit))
    else begin
        chk_cnt++;
        $display("FAIL enable_exclusive: rx=%b tx=%b required not both 1", EnableReceive, EnableTransmit);
    end

    function automatic logic [5:0] exp_vec();
        logic rx_on;
        logic tx_on;
        rx_on = (m_mode == MD_RX);
        tx_on = (m_mode == MD_TX);
        return {rx_on, tx_on, rx_on && (m_age >= SETTLE), tx_on && (m_age >= SETTLE),
                m_abort, m_mode != MD_IDLE};
    endfunction

    task automatic model_reset();
        m_mode  = MD_IDLE;
        m_age   = 0;
        m_abort = 1'b0;
    endtask

    task automatic model_step();
        int nm;
        bit ab;
        nm = m_mode;
        ab = 1'b0;
        if (m_mode == MD_IDLE) begin
            if (TxReq && !TempAlarm) nm = MD_TX;
            else if (RxReq && !TempAlarm) nm = MD_RX;
        end else if (m_mode == MD_FAULT) begin
            if (!TempAlarm && !TxReq && !RxReq) nm = MD_DEAD;
        end else if (TempAlarm) begin
            nm = MD_FAULT;
            ab = (m_mode == MD_TX);
        end else if (m_mode == MD_RX) begin
            if (TxReq || !RxReq) nm = MD_DEAD;
        end else if (m_mode == MD_TX) begin
            if (m_age + 1 == SETTLE + TXMAX) begin
                nm = MD_FAULT;
                ab = 1'b1;
            end else if (!TxReq) begin
                nm = MD_DEAD;
            end
        end else begin
            if (m_age + 1 == GUARD) nm = TxReq ? MD_TX : (RxReq ? MD_RX : MD_IDLE);
        end
        m_age   = (nm == m_mode) ? m_age + 1 : 0;
        m_mode  = nm;
        m_abort = ab;
    endtask

    // Drive inputs after a falling edge, let one rising edge happen, advance
    // the model, and return on the next falling edge for sampling.
    task automatic tick(input logic rx, input logic tx, input logic ta);
        RxReq     = rx;
        TxReq     = tx;
        TempAlarm = ta;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        RxReq = 1'b0; TxReq = 1'b0; TempAlarm = 1'b0;
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        chk_cnt++;
        if (dut_vec !== 6'b000000) $display("FAIL reset_outputs: got %b expected %b", dut_vec, 6'b000000);
        else pass_cnt++;
        ResetN = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_idle: got %b expected %b", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_rx_bringup();
        logic want;
        tick(1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if ({EnableReceive, RxReady, Busy} !== 3'b101)
            $display("FAIL rx_enable_first: got %b expected %b", {EnableReceive, RxReady, Busy}, 3'b101);
        else pass_cnt++;
        for (int i = 1; i <= SETTLE; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            want = (i == SETTLE);
            chk_cnt++;
            if (RxReady !== want) $display("FAIL rx_ready_timing: cycle %0d got %b expected %b", i, RxReady, want);
            else pass_cnt++;
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rx_bringup_model: got %b expected %b", dut_vec, exp_vec());
            else pass_cnt++;
        end
        drain();
    endtask

    task automatic test_rx_to_tx();
        int n;
        for (int i = 0; i <= SETTLE; i++) tick(1'b1, 1'b0, 1'b0);
        n = 0;
        tick(1'b1, 1'b1, 1'b0);
        while (EnableTransmit !== 1'b1 && n < 20) begin
            chk_cnt++;
            if ({EnableReceive, EnableTransmit, RxReady, TxReady} !== 4'b0000)
                $display("FAIL guard_dead_time: got %b expected %b", {EnableReceive, EnableTransmit, RxReady, TxReady}, 4'b0000);
            else pass_cnt++;
            n++;
            tick(1'b1, 1'b1, 1'b0);
        end
        chk_cnt++;
        if (n != GUARD) $display("FAIL guard_length: got %0d expected %0d", n, GUARD);
        else pass_cnt++;
        n = 0;
        while (TxReady !== 1'b1 && n < 20) begin
            n++;
            tick(1'b1, 1'b1, 1'b0);
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL rx_to_tx_model: got %b expected %b", dut_vec, exp_vec());
            else pass_cnt++;
        end
        chk_cnt++;
        if (n != SETTLE) $display("FAIL tx_settle_length: got %0d expected %0d", n, SETTLE);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_simultaneous();
        tick(1'b1, 1'b1, 1'b0);
        chk_cnt++;
        if ({EnableReceive, EnableTransmit} !== 2'b01)
            $display("FAIL simultaneous_tx_wins: got %b expected %b", {EnableReceive, EnableTransmit}, 2'b01);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL simultaneous_model: got %b expected %b", dut_vec, exp_vec());
            else pass_cnt++;
        end
        drain();
    endtask

    task automatic test_tx_timeout();
        int n;
        tick(1'b0, 1'b1, 1'b0);
        n = 0;
        while (TxReady !== 1'b1 && n < 20) begin
            n++;
            tick(1'b0, 1'b1, 1'b0);
        end
        n = 0;
        while (TxAbort !== 1'b1 && n < 1100) begin
            n++;
            tick(1'b0, 1'b1, 1'b0);
            if (TxAbort !== 1'b1) begin
                chk_cnt++;
                if (dut_vec !== exp_vec()) $display("FAIL tx_on_model: got %b expected %b", dut_vec, exp_vec());
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (n != TXMAX) $display("FAIL tx_timeout_dwell: got %0d expected %0d", n, TXMAX);
        else pass_cnt++;
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL tx_timeout_model: got %b expected %b", dut_vec, exp_vec());
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            chk_cnt++;
            if (dut_vec !== 6'b000001) $display("FAIL fault_hold: got %b expected %b", dut_vec, 6'b000001);
            else pass_cnt++;
        end
        for (int i = 1; i <= GUARD + 1; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk_cnt++;
            if (Busy !== (i <= GUARD)) $display("FAIL fault_release_busy: cycle %0d got %b expected %b", i, Busy, (i <= GUARD));
            else pass_cnt++;
        end
    endtask

    task automatic test_temp_alarm();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        chk_cnt++;
        if (dut_vec !== 6'b000011) $display("FAIL temp_abort: got %b expected %b", dut_vec, 6'b000011);
        else pass_cnt++;
        tick(1'b0, 1'b1, 1'b1);
        chk_cnt++;
        if (dut_vec !== 6'b000001) $display("FAIL temp_pulse_width: got %b expected %b", dut_vec, 6'b000001);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL fault_needs_release: got %b expected %b", dut_vec, exp_vec());
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk_cnt++;
            if (dut_vec !== exp_vec()) $display("FAIL fault_exit_model: got %b expected %b", dut_vec, exp_vec());
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= SETTLE; i++) tick(1'b1, 1'b0, 1'b0);
        #2;
        ResetN = 1'b0;
        #1;
        chk_cnt++;
        if (dut_vec !== 6'b000000) $display("FAIL async_reset: got %b expected %b", dut_vec, 6'b000000);
        else pass_cnt++;
        RxReq = 1'b0;
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        chk_cnt++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_release_idle: got %b expected %b", dut_vec, exp_vec());
        else pass_cnt++;
    endtask

    task automatic test_random();
        int cyc;
        int hold;
        logic r;
        logic t;
        logic a;
        cyc = 0;
        while (cyc < 4000) begin
            r    = 1'($urandom_range(0, 1));
            t    = 1'($urandom_range(0, 1));
            a    = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 19) == 0) ? 1100 : int'($urandom_range(1, 30));
            for (int i = 0; i < hold; i++) begin
                tick(r, t, a);
                cyc++;
                chk_cnt++;
                if (dut_vec !== exp_vec())
                    $display("FAIL random_model: cycle %0d got %b expected %b", cyc, dut_vec, exp_vec());
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx_bringup();
        test_rx_to_tx();
        test_simultaneous();
        test_tx_timeout();
        test_temp_alarm();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
